cla_seq_subtractor: RTL and testbench
=====================================

// Module: cla_seq_subtractor
// PURPOSE
//  Digit-serial unsigned subtractor: computes d = a - b - bin over WIDTH bits, one 4-bit
//  carry-lookahead slice per clock (a + ~b + ~borrow). It is the subtract-direction
//  companion to the 4-bit CLA adder. It is a multi-cycle datapath unit behind a
//  start/busy/done handshake, used where area matters more than latency.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 4
// PORTS
//  clk    in   1      rising-edge clock (only clock)
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend, captured on the accepting edge
//  b      in   WIDTH  subtrahend, captured on the accepting edge
//  bin    in   1      borrow-in, captured on the accepting edge
//  busy   out  1      1 while slices are being computed (state RUN)
//  done   out  1      1-cycle pulse: d/bout/zero valid
//  d      out  WIDTH  difference; held from done until the next accepted start
//  bout   out  1      borrow-out (1 = a < b + bin)
//  zero   out  1      1 when final d == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, d=0, bout=0, zero=0;
//    operand regs and slice counter cleared. Aborts any operation in flight.
//    No done is produced for an aborted operation.
//  - N = WIDTH/4 slices. FSM states: IDLE, RUN, DONE.
//  - IDLE: start=1 at edge E0 -> latch a, b; borrow=bin; cnt=0; go RUN.
//    start=0 -> stay in IDLE.
//  - RUN: each edge computes slice k=cnt: {c4,s}=a[4k+:4]+~b[4k+:4]+~borrow using
//    4-bit lookahead (p=a^~b, g=a&~b, carries from p/g only, no ripple); write
//    s into d[4k+:4]; borrow<=~c4; cnt++.
//    The edge computing slice N-1 (edge EN) moves the FSM to DONE and registers
//    bout=~c4 and zero=(final d==0).
//  - DONE: done=1 for exactly one cycle (between EN and EN+1); unconditional
//    return to IDLE at EN+1. Result latency: done high N cycles after E0.
//  - busy=1 exactly in RUN (N cycles). start is ignored in RUN and DONE and is
//    not queued. Back-to-back operation: the next start is accepted in IDLE,
//    so minimum issue interval is N+2 cycles.
//  - d bits of slices not yet computed keep their previous value during RUN. d is
//    only guaranteed valid while done=1 and afterwards until the next start is
//    accepted.
//  - Arithmetic is modulo 2^WIDTH. Underflow wraps and sets bout=1.
//    Example: 0 - 1 = all-ones, bout=1.
//  - a, b and bin may change freely after E0 (they are captured, not re-sampled).
// CONFIGURATION
//  SUB_SAT_EN defined: unsigned saturation. At EN, if the final borrow=1, d is
//    forced to 0 and zero=1. bout still reports 1 (underflow flag).
//  SUB_SAT_EN undefined: wrap-around result as above. There is no clamp logic.
//  Handshake and latency are identical in both builds.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x0234, bin=0, start at E0 -> busy for 4 cycles, done at
//     E0+4; d=0x1000, bout=0, zero=0.
//  2. a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, zero=0.
//     With SUB_SAT_EN: d=0x0000, bout=1, zero=1.
//  3. a=0xFFFF, b=0xFFFF, bin=1 -> d=0xFFFF, bout=1. Same with bin=0 -> d=0x0000,
//     bout=0, zero=1.
//  4. Cross-slice borrow: a=0x1000, b=0x0001, bin=0 -> d=0x0FFF, bout=0
//     (borrow propagates through 3 slices).
//  5. start pulsed again in RUN and in DONE with other operands -> ignored;
//     exactly one done; d reflects the first operands only.
//  6. rst_n low 2 cycles into RUN -> outputs 0 immediately (async); no done.
//     A fresh start after release gives a correct result at the correct latency.

Source files
------------

// File: rtl/cla_seq_subtractor.sv
// cla_seq_subtractor
//   Digit-serial unsigned subtractor. It computes d = a - b - bin over WIDTH bits.
//   Each clock processes one 4-bit carry-lookahead slice as a + ~b + ~borrow.
//   Operation is driven by a start/busy/done handshake.
//   A new request is accepted only in IDLE. The result follows after N = WIDTH/4
//   cycles, and the minimum issue interval is N+2 cycles.
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, sampled only in IDLE
//     a      in   WIDTH  minuend, captured on the accepting edge
//     b      in   WIDTH  subtrahend, captured on the accepting edge
//     bin    in   1      borrow-in, captured on the accepting edge
//     busy   out  1      high while slices are computed (RUN)
//     done   out  1      one-cycle pulse; d/bout/zero valid
//     d      out  WIDTH  difference, held until the next accepted start
//     bout   out  1      borrow-out (1 = a < b + bin)
//     zero   out  1      final d == 0
//
//   Build option SUB_SAT_EN: clamps an underflowing result to 0 and sets zero.
//   bout still reports the underflow. Without the macro the result wraps
//   modulo 2^WIDTH.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice per edge, cnt = slice index
//   DONE  | result valid, done pulse, back to IDLE

module cla_seq_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             borrow_q, bout_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic [CW+1:0]    base;
  logic [3:0]       a4, nb4, p, g, s;
  logic             cin, c1, c2, c3, c4;
  logic [WIDTH-1:0] d_slice;
  logic             last_slice;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // One 4-bit lookahead slice. Each carry comes directly from p/g and cin.
  always_comb begin
    base = {cnt_q, 2'b00};
    a4   = a_q[base +: 4];
    nb4  = ~b_q[base +: 4];
    cin  = ~borrow_q;
    p    = a4 ^ nb4;
    g    = a4 & nb4;
    c1   = g[0] | (p[0] & cin);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ {c3, c2, c1, cin};
    d_slice = d_q;
    d_slice[base +: 4] = s;
    last_slice = (cnt_q == LAST);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          borrow_q <= ~c4;
          cnt_q    <= cnt_q + 1'b1;
          d_q      <= d_slice;
          if (last_slice) begin
            bout_q <= ~c4;
`ifdef SUB_SAT_EN
            if (!c4) begin
              d_q    <= '0;
              zero_q <= 1'b1;
            end else begin
              zero_q <= (d_slice == '0);
            end
`else
            zero_q <= (d_slice == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_seq_subtractor.sv
module tb_cla_seq_subtractor;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout, zero;
  logic [WIDTH-1:0] d;

  int n_cmp  = 0;
  int n_fail = 0;

  cla_seq_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction over WIDTH+1 bits
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                       output logic [WIDTH-1:0] ed, output logic eb, output logic ez);
    logic [WIDTH:0] r;
    r  = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    ed = r[WIDTH-1:0];
    eb = r[WIDTH];
`ifdef SUB_SAT_EN
    if (eb) ed = '0;
`endif
    ez = (ed == '0);
  endtask

  // Issue one operation from a negedge; optionally pulse start in RUN and DONE.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin, input bit inject);
    logic [WIDTH-1:0] ed;
    logic eb, ez;
    int cyc, busy_n;
    model(ta, tb, tbin, ed, eb, ez);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    cyc = 0; busy_n = 0;
    while (!done && cyc < 4 * N) begin
      if (busy) busy_n++;
      if (inject && cyc == 1) begin
        start = 1'b1; a = ~ta; b = tb ^ 16'h5a5a;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(N));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(N));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " d"}, 32'(d), 32'(ed));
    check({tag, " bout"}, 32'(bout), 32'(eb));
    check({tag, " zero"}, 32'(zero), 32'(ez));
    if (inject) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " done_single"}, 32'(done), 32'd0);
    if (inject) begin
      @(posedge clk);
      #1;
      check({tag, " no_requeue_busy"}, 32'(busy), 32'd0);
      check({tag, " no_requeue_done"}, 32'(done), 32'd0);
      check({tag, " d_held"}, 32'(d), 32'(ed));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int seen_done;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 16'h1234, 16'h0234, 1'b0, 1'b0);
    run_op("t2_underflow", 16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op("t3_ffff_bin1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op("t3_ffff_bin0", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    run_op("t4_cross", 16'h1000, 16'h0001, 1'b0, 1'b0);
    run_op("t5_ignore", 16'h8421, 16'h1248, 1'b1, 1'b1);

    // Abort in RUN: outputs clear asynchronously and no done appears
    @(negedge clk);
    a = 16'h4321; b = 16'h0123; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort d", 32'(d), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    seen_done = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("abort no_done", 32'(seen_done), 32'd0);
    run_op("t6_after_abort", 16'h4321, 16'h0123, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 4 == 0) ? ra : WIDTH'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), bit'(i % 7 == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
